// File: rtl/ccff_chain_loader_if.sv
// ccff_chain_loader_if: config word stream into the loader and readback word stream out of it
interface ccff_chain_loader_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] cfg_data;
    logic cfg_valid;
    logic cfg_ready;
    logic [WORD_W-1:0] rb_data;
    logic rb_valid;
    modport master (output cfg_data, cfg_valid, input cfg_ready, rb_data, rb_valid);
    modport slave (input cfg_data, cfg_valid, output cfg_ready, rb_data, rb_valid);
endinterface

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serialises config words LSB first into a ccff chain and returns the displaced tail bits as words
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 5,
    parameter int WORD_W = 8,
    parameter int CNT_W = $clog2(CHAIN_LEN + 1)
) (
    input  logic prog_clk,
    input  logic prog_reset,
    input  logic start,
    input  logic abort,
    ccff_chain_loader_if.slave cfg,
    output logic ccff_head,
    input  logic ccff_tail,
    output logic shift_en,
    output logic busy,
    output logic done
);
    localparam int WB_W = $clog2(WORD_W + 1);
    localparam int RB_W = WORD_W > 1 ? $clog2(WORD_W) : 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    logic [1:0] state;
    logic [WORD_W-1:0] sreg;
    logic [WORD_W-1:0] rb_sreg;
    logic [WORD_W-1:0] rb_next;
    logic [WORD_W-1:0] rb_q;
    logic [WB_W-1:0] wbits;
    logic [CNT_W-1:0] bit_cnt;
    logic [RB_W-1:0] rbcnt;
    logic rb_v;
    logic ready;
    logic accept;
    logic last;
    logic rb_fire;
    assign cfg.cfg_ready = ready;
    assign cfg.rb_data = rb_q;
    assign cfg.rb_valid = rb_v;
    // decode outputs from flops; ready also refills on the last bit of a word so words stream without a bubble
    always_comb begin
        busy = state == LOAD;
        done = state == DONE;
        shift_en = busy && wbits != '0;
        ccff_head = sreg[0];
        ready = busy && !abort && (wbits == '0 || (wbits == WB_W'(1) && shift_en));
        accept = cfg.cfg_valid && ready;
        last = shift_en && bit_cnt == CNT_W'(CHAIN_LEN - 1);
        rb_fire = last || rbcnt == RB_W'(WORD_W - 1);
        rb_next = rb_sreg;
        rb_next[rbcnt] = ccff_tail;
    end
    // state machine, word buffer, shifted-bit count and readback packing
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state <= IDLE;
            sreg <= '0;
            wbits <= '0;
            bit_cnt <= '0;
            rb_sreg <= '0;
            rbcnt <= '0;
            rb_q <= '0;
            rb_v <= 1'b0;
        end else begin
            rb_v <= 1'b0;
            if (abort) begin
                state <= IDLE;
                wbits <= '0;
            end else if (start && state != LOAD) begin
                state <= LOAD;
                bit_cnt <= '0;
                wbits <= '0;
                rb_sreg <= '0;
                rbcnt <= '0;
            end else if (state == LOAD) begin
                if (shift_en) begin
                    sreg <= sreg >> 1;
                    wbits <= wbits - WB_W'(1);
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    rb_sreg <= rb_fire ? '0 : rb_next;
                    rbcnt <= rb_fire ? '0 : rbcnt + RB_W'(1);
                    if (rb_fire) begin
                        rb_q <= rb_next;
                        rb_v <= 1'b1;
                    end
                end
                if (accept) begin
                    sreg <= cfg.cfg_data;
                    wbits <= WB_W'(WORD_W);
                end
                if (last) begin
                    state <= DONE;
                    wbits <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: randomized directed bench with behavioural chains and a stream-level reference model
module tb_ccff_chain_loader;
    localparam int W = 8;
    localparam int LA = 5;
    localparam int LB = 20;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0, abort_a = 1'b0, tail_a, head_a, sh_a, busy_a, done_a;
    logic start_b = 1'b0, abort_b = 1'b0, tail_b, head_b, sh_b, busy_b, done_b;
    logic ld_a = 1'b0, ld_b = 1'b0;
    logic [LA-1:0] chain_a, pre_a;
    logic [LB-1:0] chain_b, pre_b;
    int ntests = 0;
    int nfail = 0;
    ccff_chain_loader_if #(.WORD_W(W)) ia ();
    ccff_chain_loader_if #(.WORD_W(W)) ib ();
    ccff_chain_loader #(.CHAIN_LEN(LA), .WORD_W(W)) dut_a (
        .prog_clk(clk), .prog_reset(rst), .start(start_a), .abort(abort_a), .cfg(ia),
        .ccff_head(head_a), .ccff_tail(tail_a), .shift_en(sh_a), .busy(busy_a), .done(done_a)
    );
    ccff_chain_loader #(.CHAIN_LEN(LB), .WORD_W(W)) dut_b (
        .prog_clk(clk), .prog_reset(rst), .start(start_b), .abort(abort_b), .cfg(ib),
        .ccff_head(head_b), .ccff_tail(tail_b), .shift_en(sh_b), .busy(busy_b), .done(done_b)
    );
    always #5 clk = ~clk;
    // behavioural chains: bit 0 sits behind ccff_head, the top bit drives ccff_tail
    always @(posedge clk) chain_a <= ld_a ? pre_a : sh_a ? {chain_a[LA-2:0], head_a} : chain_a;
    always @(posedge clk) chain_b <= ld_b ? pre_b : sh_b ? {chain_b[LB-2:0], head_b} : chain_b;
    assign tail_a = chain_a[LA-1];
    assign tail_b = chain_b[LB-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // one load on the 20-bit chain: gap = ready cycles withheld before word 1,
    // abort_at = abort during that shift, restart_at = start pulse during that shift
    task automatic run_load(input int gap, input int abort_at, input int restart_at);
        logic [W-1:0] words [3];
        logic [W-1:0] exp_rb [3];
        logic [W-1:0] got_rb [$];
        logic [LB-1:0] exp_chain;
        int acc_at [3];
        int idx = 0, g = gap, nsh = 0, first = -1, last = -1, cyc = 0, quiet = 0;
        bit acc = 1'b0, fin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            words[i] = W'($urandom);
            exp_rb[i] = '0;
        end
        @(negedge clk);
        pre_b = LB'($urandom);
        ld_b = 1'b1;
        @(negedge clk);
        ld_b = 1'b0;
        exp_chain = '0;
        for (int k = 0; k < LB; k++) begin
            exp_chain[LB-1-k] = words[k/W][k%W];
            exp_rb[k/W][k%W] = pre_b[LB-1-k];
        end
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        chk("enter_load", {done_b, busy_b}, 2'b01);
        while (!fin && cyc < 200) begin
            if (acc) idx++;
            if (sh_b) begin
                nsh++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            if (ib.rb_valid) got_rb.push_back(ib.rb_data);
            if (done_b || abort_b) fin = 1'b1;
            else begin
                abort_b = sh_b && nsh == abort_at;
                start_b = sh_b && nsh == restart_at;
                #1;
                ib.cfg_valid = 1'b0;
                if (!abort_b && idx < 3) begin
                    if (idx == 1 && g > 0) begin
                        if (ib.cfg_ready) g--;
                    end else begin
                        ib.cfg_valid = 1'b1;
                        ib.cfg_data = words[idx];
                    end
                end
                acc = ib.cfg_valid && ib.cfg_ready;
                if (acc) acc_at[idx] = cyc;
                cyc++;
                @(negedge clk);
            end
        end
        abort_b = 1'b0;
        start_b = 1'b0;
        ib.cfg_valid = 1'b0;
        chk("load_finished_in_budget", fin, 1);
        if (abort_at > 0) begin
            chk("abort_next_cycle", {sh_b, busy_b, done_b}, 3'b000);
            chk("abort_shift_count", nsh, abort_at);
            repeat (4) begin
                @(negedge clk);
                quiet += sh_b + ib.rb_valid + done_b + busy_b;
            end
            chk("abort_quiet", quiet, 0);
            chk("abort_no_rb", got_rb.size(), 0);
        end else begin
            chk("shift_count", nsh, LB);
            chk("shift_span", last - first + 1, LB + gap);
            chk("chain_contents", exp_chain, chain_b);
            chk("words_accepted", idx, 3);
            chk("done_state", {done_b, busy_b, ib.cfg_ready}, 3'b100);
            chk("rb_pulses", got_rb.size(), 3);
            for (int i = 0; i < 3 && i < got_rb.size(); i++) chk($sformatf("rb_word%0d", i), got_rb[i], exp_rb[i]);
            if (gap == 0) begin
                chk("ready_bit0", acc_at[0], first - 1);
                chk("ready_bit7", acc_at[1], first + 7);
                chk("ready_bit15", acc_at[2], first + 15);
            end
            @(negedge clk);
            chk("rb_valid_one_cycle", {ib.rb_valid, done_b, sh_b}, 3'b010);
        end
    endtask

    initial begin
        int nsh, nrb, first, last;
        logic [W-1:0] rbv;
        ia.cfg_valid = 1'b0;
        ia.cfg_data = '0;
        ib.cfg_valid = 1'b0;
        ib.cfg_data = '0;
        repeat (2) @(negedge clk);
        chk("reset_a", {head_a, sh_a, busy_a, done_a, ia.cfg_ready, ia.rb_valid, ia.rb_data}, 0);
        chk("reset_b", {head_b, sh_b, busy_b, done_b, ib.cfg_ready, ib.rb_valid, ib.rb_data}, 0);
        rst = 1'b0;
        @(negedge clk);
        // 5-bit chain of ones loaded with 0x15
        pre_a = '1;
        ld_a = 1'b1;
        @(negedge clk);
        ld_a = 1'b0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        ia.cfg_valid = 1'b1;
        ia.cfg_data = 8'h15;
        chk("t1_ready", ia.cfg_ready, 1);
        @(negedge clk);
        ia.cfg_valid = 1'b0;
        nsh = 0;
        nrb = 0;
        first = -1;
        last = -1;
        rbv = '0;
        for (int k = 0; k < 50; k++) begin
            if (sh_a) begin
                nsh++;
                if (first < 0) first = k;
                last = k;
            end
            if (ia.rb_valid) begin
                nrb++;
                rbv = ia.rb_data;
            end
            if (done_a) break;
            @(negedge clk);
        end
        chk("t1_done", done_a, 1);
        chk("t1_shifts", nsh, LA);
        chk("t1_span", last - first + 1, LA);
        chk("t1_chain", chain_a, 5'b10101);
        chk("t1_rb_pulses", nrb, 1);
        chk("t1_rb_data", rbv, 8'h1F);
        @(negedge clk);
        chk("t1_rb_hold", {ia.rb_valid, ia.rb_data}, {1'b0, 8'h1F});
        // 20-bit chain: streaming, starvation gap, abort, reload
        run_load(0, 0, 0);
        run_load(4, 0, 0);
        run_load(0, 3, 0);
        run_load(0, 0, 0);
        // reset in the middle of a load
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        ib.cfg_valid = 1'b1;
        ib.cfg_data = 8'hFF;
        @(negedge clk);
        ib.cfg_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset_busy", {busy_b, sh_b}, 2'b11);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_mid_load", {head_b, sh_b, busy_b, done_b, ib.cfg_ready, ib.rb_valid, ib.rb_data}, 0);
        @(negedge clk);
        rst = 1'b0;
        run_load(0, 0, 0);
        // start while busy is ignored, start from DONE begins a new load
        run_load(0, 0, 5);
        repeat (3) run_load(int'($urandom_range(0, 3)), 0, 0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
